// File: rtl/disp_pkg.sv
// Display constants shared between the display receiver and the ALU result formatter.
// Segment patterns are active-high, ordered {dp,g,f,e,d,c,b,a}.
package disp_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg_display_rx_if.sv
// Digit stream from the ALU side: one {num_led, length} pair per cycle, no handshake.
interface seg_display_rx_if;
    logic [3:0] num_led;
    logic [2:0] length;

    modport master (output num_led, output length);
    modport slave  (input  num_led, input  length);
endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-code to seven-segment decoder (active-high pattern).
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:       pattern = SEG_0;
            4'd1:       pattern = SEG_1;
            4'd2:       pattern = SEG_2;
            4'd3:       pattern = SEG_3;
            4'd4:       pattern = SEG_4;
            4'd5:       pattern = SEG_5;
            4'd6:       pattern = SEG_6;
            4'd7:       pattern = SEG_7;
            4'd8:       pattern = SEG_8;
            4'd9:       pattern = SEG_9;
            CODE_MINUS: pattern = SEG_MINUS;
            default:    pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_rx.sv
// Captures the ALU digit stream into a 4-digit shift buffer and scans it onto a
// multiplexed seven-segment display, one digit per SCAN_DIV clock cycles.
module seg_display_rx
    import disp_pkg::*;
#(
    parameter int SCAN_DIV       = 12500,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_display_rx_if.slave  rx,
    output logic [7:0]       seg,
    output logic [3:0]       dig_sel,
    output logic [2:0]       digit_count,
    output logic             overflow
);

    localparam int               CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [7:0]       SEG_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [2:0]       CNT_FULL = 3'(NUM_DIGITS);

    logic [2:0]                  length_q_reg;
    logic                        digit_event;
    logic                        clear_evt;
    logic                        shift_evt;

    logic [NUM_DIGITS-1:0][3:0]  buf_reg;
    logic [NUM_DIGITS-1:0][3:0]  buf_next;
    logic [2:0]                  digit_count_reg;
    logic                        overflow_reg;

    logic [CNT_W-1:0]            scan_cnt_reg;
    logic [1:0]                  idx_reg;
    logic [7:0]                  seg_pattern;
    logic [7:0]                  seg_reg;
    logic [3:0]                  dig_sel_reg;

    // Any change of the length tag is one digit event; zero means clear.
    assign digit_event = (rx.length != length_q_reg);
    assign clear_evt   = digit_event && (rx.length == 3'd0);
    assign shift_evt   = digit_event && (rx.length != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length_q_reg <= 3'd0;
        end else begin
            length_q_reg <= rx.length;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_buf_next
            logic [3:0] shift_src;
            if (gi == 0) begin : g_head
                assign shift_src = rx.num_led;
            end else begin : g_tail
                assign shift_src = buf_reg[gi-1];
            end
            assign buf_next[gi] = clear_evt ? CODE_BLANK :
                                  shift_evt ? shift_src  : buf_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg         <= {NUM_DIGITS{CODE_BLANK}};
            digit_count_reg <= 3'd0;
            overflow_reg    <= 1'b0;
        end else begin
            buf_reg <= buf_next;
            if (clear_evt) begin
                digit_count_reg <= 3'd0;
                overflow_reg    <= 1'b0;
            end else if (shift_evt) begin
                if (digit_count_reg != CNT_FULL) begin
                    digit_count_reg <= digit_count_reg + 3'd1;
                end
                // Only a real (non-blank) digit falling off the top counts as lost.
                if ((digit_count_reg == CNT_FULL) && (buf_reg[NUM_DIGITS-1] != CODE_BLANK)) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            idx_reg      <= 2'd0;
        end else if (scan_cnt_reg == CNT_LAST) begin
            scan_cnt_reg <= '0;
            idx_reg      <= idx_reg + 2'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + CNT_W'(1);
        end
    end

    seg7_decode u_decode (
        .code    (buf_reg[idx_reg]),
        .pattern (seg_pattern)
    );

    // seg and dig_sel share one register stage so they always switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg     <= SEG_BLANK ^ SEG_MASK;
            dig_sel_reg <= 4'b0001;
        end else begin
            seg_reg     <= seg_pattern ^ SEG_MASK;
            dig_sel_reg <= 4'b0001 << idx_reg;
        end
    end

    assign seg         = seg_reg;
    assign dig_sel     = dig_sel_reg;
    assign digit_count = digit_count_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_seg_display_rx.sv
// Directed bench for seg_display_rx: active-high and active-low instances share one stream.
module tb_seg_display_rx;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] seg_h, seg_l;
    logic [3:0] dsel_h, dsel_l;
    logic [2:0] cnt_h, cnt_l;
    logic       ovf_h, ovf_l;

    int tests = 0;
    int fails = 0;

    logic [7:0] seen_h [4];
    logic [7:0] seen_l [4];

    seg_display_rx_if bus ();

    seg_display_rx #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .rx(bus),
        .seg(seg_h), .dig_sel(dsel_h), .digit_count(cnt_h), .overflow(ovf_h)
    );

    seg_display_rx #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .rx(bus),
        .seg(seg_l), .dig_sel(dsel_l), .digit_count(cnt_l), .overflow(ovf_l)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] n, input logic [2:0] l);
        @(negedge clk);
        bus.num_led = n;
        bus.length  = l;
    endtask

    // Let the scan settle, then record what each digit slot shows over one full frame.
    task automatic capture_frame();
        repeat (20) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            seen_h[d] = 8'hxx;
            seen_l[d] = 8'hxx;
        end
        for (int c = 0; c < 5 * SD; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (dsel_h == (4'b0001 << d)) begin
                    seen_h[d] = seg_h;
                    seen_l[d] = seg_l;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_sel;
        rst_n = 1'b0;
        bus.num_led = 4'hF;
        bus.length  = 3'd0;
        repeat (3) @(negedge clk);
        tests++;
        if (dsel_h !== 4'b0001 || seg_h !== 8'h00 || seg_l !== 8'hFF || cnt_h !== 3'd0 || ovf_h !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals: got sel=%b seg=%h segn=%h cnt=%0d ovf=%b, expected 0001 00 ff 0 0",
                     dsel_h, seg_h, seg_l, cnt_h, ovf_h);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_sel = 4'b0001 << (((k - 1) / SD) % 4);
            tests++;
            if (dsel_h !== exp_sel || seg_h !== 8'h00 || cnt_h !== 3'd0 || ovf_h !== 1'b0) begin
                fails++;
                $display("FAIL reset_scan cycle %0d: got sel=%b seg=%h cnt=%0d ovf=%b, expected sel=%b seg=00 cnt=0 ovf=0",
                         k, dsel_h, seg_h, cnt_h, ovf_h, exp_sel);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_three_digits();
        logic [7:0] e [4];
        e = '{8'h4F, 8'h5B, 8'h06, 8'h00};
        drive(4'd1, 3'd1);
        drive(4'd2, 3'd2);
        drive(4'd3, 3'd3);
        @(negedge clk);
        tests++;
        if (cnt_h !== 3'd3) begin
            fails++;
            $display("FAIL three_count: got %0d expected 3", cnt_h);
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (seen_h[d] !== e[d] || seen_l[d] !== ~e[d]) begin
                fails++;
                $display("FAIL three_digit%0d: got %h/%h expected %h/%h", d, seen_h[d], seen_l[d], e[d], ~e[d]);
            end
        end
        $display("[TB] test_three_digits done");
    endtask

    task automatic test_overflow();
        logic [7:0] e [4];
        e = '{8'h6D, 8'h66, 8'h4F, 8'h5B};
        drive(4'hF, 3'd0);
        for (int i = 1; i <= 5; i++) begin
            drive(4'(i), 3'(i));
            if (i == 4) begin
                @(negedge clk);
                tests++;
                if (cnt_h !== 3'd4 || ovf_h !== 1'b0) begin
                    fails++;
                    $display("FAIL full_no_ovf: got cnt=%0d ovf=%b expected 4 0", cnt_h, ovf_h);
                end
            end
        end
        @(negedge clk);
        tests++;
        if (cnt_h !== 3'd4 || ovf_h !== 1'b1 || ovf_l !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flags: got cnt=%0d ovf=%b/%b expected 4 1", cnt_h, ovf_h, ovf_l);
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (seen_h[d] !== e[d]) begin
                fails++;
                $display("FAIL ovf_digit%0d: got %h expected %h", d, seen_h[d], e[d]);
            end
        end
        drive(4'd7, 3'd0);
        @(negedge clk);
        tests++;
        if (cnt_h !== 3'd0 || ovf_h !== 1'b0) begin
            fails++;
            $display("FAIL clear_flags: got cnt=%0d ovf=%b expected 0 0", cnt_h, ovf_h);
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (seen_h[d] !== 8'h00 || seen_l[d] !== 8'hFF) begin
                fails++;
                $display("FAIL clear_digit%0d: got %h/%h expected 00/ff", d, seen_h[d], seen_l[d]);
            end
        end
        $display("[TB] test_overflow done");
    endtask

    task automatic test_minus();
        logic [7:0] eh [4];
        logic [7:0] el [4];
        eh = '{8'h07, 8'h40, 8'h00, 8'h00};
        el = '{8'hF8, 8'hBF, 8'hFF, 8'hFF};
        drive(4'hA, 3'd1);
        drive(4'd7, 3'd2);
        @(negedge clk);
        tests++;
        if (cnt_h !== 3'd2) begin
            fails++;
            $display("FAIL minus_count: got %0d expected 2", cnt_h);
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (seen_h[d] !== eh[d] || seen_l[d] !== el[d]) begin
                fails++;
                $display("FAIL minus_digit%0d: got %h/%h expected %h/%h", d, seen_h[d], seen_l[d], eh[d], el[d]);
            end
        end
        $display("[TB] test_minus done");
    endtask

    task automatic test_hold_no_shift();
        drive(4'hF, 3'd0);
        drive(4'd9, 3'd3);
        for (int i = 0; i < 8; i++) drive(4'(i), 3'd3);
        @(negedge clk);
        tests++;
        if (cnt_h !== 3'd1) begin
            fails++;
            $display("FAIL hold_count: got %0d expected 1", cnt_h);
        end
        capture_frame();
        tests++;
        if (seen_h[0] !== 8'h6F || seen_h[1] !== 8'h00) begin
            fails++;
            $display("FAIL hold_digits: got d0=%h d1=%h expected 6f 00", seen_h[0], seen_h[1]);
        end
        drive(4'd4, 3'd1);
        @(negedge clk);
        tests++;
        if (cnt_h !== 3'd2) begin
            fails++;
            $display("FAIL decrease_count: got %0d expected 2", cnt_h);
        end
        capture_frame();
        tests++;
        if (seen_h[0] !== 8'h66 || seen_h[1] !== 8'h6F || seen_h[2] !== 8'h00) begin
            fails++;
            $display("FAIL decrease_digits: got %h %h %h expected 66 6f 00", seen_h[0], seen_h[1], seen_h[2]);
        end
        $display("[TB] test_hold_no_shift done");
    endtask

    task automatic test_mid_reset();
        drive(4'hF, 3'd0);
        drive(4'd1, 3'd1);
        drive(4'd2, 3'd2);
        drive(4'd3, 3'd3);
        drive(4'd4, 3'd4);
        @(negedge clk);
        tests++;
        if (cnt_h !== 3'd4) begin
            fails++;
            $display("FAIL prefill_count: got %0d expected 4", cnt_h);
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.num_led = 4'd8;
        bus.length  = 3'd2;
        #1;
        tests++;
        if (dsel_h !== 4'b0001 || seg_h !== 8'h00 || seg_l !== 8'hFF || cnt_h !== 3'd0 || ovf_h !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got sel=%b seg=%h segn=%h cnt=%0d ovf=%b expected 0001 00 ff 0 0",
                     dsel_h, seg_h, seg_l, cnt_h, ovf_h);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cnt_h !== 3'd1) begin
            fails++;
            $display("FAIL release_count: got %0d expected 1", cnt_h);
        end
        capture_frame();
        tests++;
        if (seen_h[0] !== 8'h7F || seen_h[1] !== 8'h00 || seen_h[3] !== 8'h00) begin
            fails++;
            $display("FAIL release_digits: got d0=%h d1=%h d3=%h expected 7f 00 00", seen_h[0], seen_h[1], seen_h[3]);
        end
        $display("[TB] test_mid_reset done");
    endtask

    initial begin
        test_reset();
        test_three_digits();
        test_overflow();
        test_minus();
        test_hold_no_shift();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
